// File: rtl/vga_text_console.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : vga_text_console                                              |
// | Purpose  : byte-stream text console writing {attr,char} symbols to VRAM  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module vga_text_console #(
  parameter int         COLS           = 80,
  parameter int         ROWS           = 30,
  parameter logic [7:0] DEF_ATTR       = 8'h0F,
  parameter bit         CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ch_valid,
  input  logic [7:0]  ch_data,
  input  logic [7:0]  ch_attr,
  output logic        ch_ready,
  output logic        busy,
  output logic [10:0] ram_addr,
  output logic [3:0]  ram_we,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  output logic [4:0]  cur_row,
  output logic [6:0]  cur_col
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PUT    = 3'd1,
    S_SCR_RD = 3'd2,
    S_SCR_WR = 3'd3,
    S_FILL   = 3'd4,
    S_CLEAR  = 3'd5
  } state_t;

  localparam state_t      c_RST_STATE = CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
  localparam logic [10:0] c_HALF      = 11'(COLS / 2);
  localparam logic [10:0] c_LAST_WORD = 11'(ROWS * COLS / 2 - 1);
  localparam logic [10:0] c_FILL0     = 11'((ROWS - 1) * COLS / 2);
  localparam logic [4:0]  c_LAST_ROW  = 5'(ROWS - 1);
  localparam logic [6:0]  c_LAST_COL  = 7'(COLS - 1);

  state_t      r_state, w_state_nx;
  logic [4:0]  r_row, w_row_nx;
  logic [6:0]  r_col, w_col_nx;
  logic [7:0]  r_char, w_char_nx;
  logic [7:0]  r_attr, w_attr_nx;
  logic [10:0] r_cnt, w_cnt_nx;
  logic        r_ready;
  logic        r_use_rd;
  logic [31:0] r_wdata;

  logic [10:0] w_addr;
  logic [3:0]  w_we;
  logic [31:0] w_wdata;
  logic        w_use_rd;
  logic [11:0] w_sym_idx;
  logic [15:0] w_sym;
  logic [15:0] w_blank;

  assign w_sym_idx = 12'(r_row) * 12'(COLS) + 12'(r_col);
  assign w_sym     = {r_attr, r_char};
  assign w_blank   = {r_attr, 8'h20};

  always_comb begin
    w_state_nx = r_state;
    w_row_nx   = r_row;
    w_col_nx   = r_col;
    w_char_nx  = r_char;
    w_attr_nx  = r_attr;
    w_cnt_nx   = r_cnt;
    w_addr     = '0;
    w_we       = '0;
    w_wdata    = '0;
    w_use_rd   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (ch_valid && r_ready) begin
          w_char_nx = ch_data;
          w_attr_nx = ch_attr;
          case (ch_data)
            8'h0A: begin
              w_col_nx = '0;
              if (r_row == c_LAST_ROW) begin
                w_state_nx = S_SCR_RD;
                w_cnt_nx   = c_HALF;
              end else begin
                w_row_nx = r_row + 5'd1;
              end
            end
            8'h0D: w_col_nx = '0;
            8'h08: if (r_col != '0) w_col_nx = r_col - 7'd1;
            8'h0C: begin
              w_row_nx   = '0;
              w_col_nx   = '0;
              w_cnt_nx   = '0;
              w_state_nx = S_CLEAR;
            end
            default: w_state_nx = S_PUT;
          endcase
        end
      end
      S_PUT: begin
        w_addr     = 11'(w_sym_idx >> 1);
        w_we       = r_col[0] ? 4'b0011 : 4'b1100;
        w_wdata    = {w_sym, w_sym};
        w_state_nx = S_IDLE;
        if (r_col < c_LAST_COL) begin
          w_col_nx = r_col + 7'd1;
        end else begin
          w_col_nx = '0;
          if (r_row == c_LAST_ROW) begin
            w_state_nx = S_SCR_RD;
            w_cnt_nx   = c_HALF;
          end else begin
            w_row_nx = r_row + 5'd1;
          end
        end
      end
      S_SCR_RD: begin
        w_addr     = r_cnt;
        w_state_nx = S_SCR_WR;
      end
      S_SCR_WR: begin
        // Data comes straight from the read port one cycle after the read address.
        w_addr   = r_cnt - c_HALF;
        w_we     = 4'hF;
        w_use_rd = 1'b1;
        if (r_cnt == c_LAST_WORD) begin
          w_cnt_nx   = c_FILL0;
          w_state_nx = S_FILL;
        end else begin
          w_cnt_nx   = r_cnt + 11'd1;
          w_state_nx = S_SCR_RD;
        end
      end
      S_FILL, S_CLEAR: begin
        w_addr  = r_cnt;
        w_we    = 4'hF;
        w_wdata = {w_blank, w_blank};
        if (r_cnt == c_LAST_WORD) begin
          w_cnt_nx   = '0;
          w_state_nx = S_IDLE;
        end else begin
          w_cnt_nx = r_cnt + 11'd1;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // RAM port is registered, so every write lands one cycle after its state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= c_RST_STATE;
      r_row    <= '0;
      r_col    <= '0;
      r_char   <= '0;
      r_attr   <= DEF_ATTR;
      r_cnt    <= '0;
      r_ready  <= 1'b0;
      r_use_rd <= 1'b0;
      r_wdata  <= '0;
      ram_addr <= '0;
      ram_we   <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_row    <= w_row_nx;
      r_col    <= w_col_nx;
      r_char   <= w_char_nx;
      r_attr   <= w_attr_nx;
      r_cnt    <= w_cnt_nx;
      r_ready  <= (w_state_nx == S_IDLE);
      r_use_rd <= w_use_rd;
      r_wdata  <= w_wdata;
      ram_addr <= w_addr;
      ram_we   <= w_we;
    end
  end

  assign ram_wdata = r_use_rd ? ram_rdata : r_wdata;
  assign ch_ready  = r_ready;
  assign busy      = (r_state == S_SCR_RD) || (r_state == S_SCR_WR) ||
                     (r_state == S_FILL)   || (r_state == S_CLEAR);
  assign cur_row   = r_row;
  assign cur_col   = r_col;

endmodule
`default_nettype wire

// File: tb/tb_vga_text_console.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_vga_text_console                                           |
// | Purpose  : randomized bench with a screen-level reference model          |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_vga_text_console;

  localparam int COLS  = 80;
  localparam int ROWS  = 30;
  localparam int WORDS = ROWS * COLS / 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ch_valid = 1'b0;
  logic [7:0]  ch_data = 8'h00;
  logic [7:0]  ch_attr = 8'h00;
  logic        ch_ready;
  logic        busy;
  logic [10:0] ram_addr;
  logic [3:0]  ram_we;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = 32'h0;
  logic [4:0]  cur_row;
  logic [6:0]  cur_col;

  int total = 0;
  int bad   = 0;

  vga_text_console dut (
    .clk(clk), .reset(reset), .ch_valid(ch_valid), .ch_data(ch_data),
    .ch_attr(ch_attr), .ch_ready(ch_ready), .busy(busy), .ram_addr(ram_addr),
    .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .cur_row(cur_row), .cur_col(cur_col)
  );

  always #5 clk = ~clk;

  // Dual-port VRAM stand-in: byte-enabled write, registered read.
  logic [31:0] mem [0:2047];
  logic [14:0] wlog [$];
  int oob_writes = 0;

  always @(posedge clk) begin
    if (ram_we != 4'h0) begin
      if (ram_addr >= 11'(WORDS)) oob_writes++;
      wlog.push_back({ram_we, ram_addr});
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
    ram_rdata <= mem[ram_addr];
  end

  // Reference model: the screen as a 2-D grid of symbols plus a cursor.
  logic [15:0] scr [0:ROWS-1][0:COLS-1];
  int m_row, m_col;

  task automatic model_fill(input logic [7:0] a);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) scr[r][c] = {a, 8'h20};
  endtask

  task automatic model_scroll(input logic [7:0] a);
    for (int r = 0; r < ROWS - 1; r++)
      for (int c = 0; c < COLS; c++) scr[r][c] = scr[r+1][c];
    for (int c = 0; c < COLS; c++) scr[ROWS-1][c] = {a, 8'h20};
  endtask

  task automatic model_newline(input logic [7:0] a);
    m_col = 0;
    if (m_row == ROWS - 1) model_scroll(a);
    else m_row++;
  endtask

  task automatic model_apply(input logic [7:0] d, input logic [7:0] a);
    case (d)
      8'h0A: model_newline(a);
      8'h0D: m_col = 0;
      8'h08: if (m_col > 0) m_col--;
      8'h0C: begin m_row = 0; m_col = 0; model_fill(a); end
      default: begin
        scr[m_row][m_col] = {a, d};
        if (m_col < COLS - 1) m_col++;
        else model_newline(a);
      end
    endcase
  endtask

  task automatic screen_diff(output int n, output int fw, output logic [31:0] got,
                             output logic [31:0] exp);
    n = 0; fw = -1; got = 32'h0; exp = 32'h0;
    for (int w = 0; w < WORDS; w++) begin
      int r;
      int c;
      logic [31:0] e;
      r = (2 * w) / COLS;
      c = (2 * w) % COLS;
      e = {scr[r][c], scr[r][c+1]};
      if (mem[w] !== e) begin
        if (n == 0) begin fw = w; got = mem[w]; exp = e; end
        n++;
      end
    end
  endtask

  function automatic logic [7:0] rand_printable();
    logic [7:0] d;
    d = 8'($urandom);
    while (d == 8'h0A || d == 8'h0D || d == 8'h08 || d == 8'h0C) d = 8'($urandom);
    return d;
  endfunction

  // Offers one byte once ch_ready is seen; returns at the negedge after acceptance.
  task automatic send_byte(input logic [7:0] d, input logic [7:0] a);
    int n;
    n = 0;
    while (!ch_ready && n < 5000) begin @(negedge clk); n++; end
    if (n >= 5000) begin
      total++; bad++;
      $display("FAIL send_timeout: ch_ready stayed %0b, required 1", ch_ready);
    end
    ch_valid = 1'b1; ch_data = d; ch_attr = a;
    model_apply(d, a);
    @(negedge clk);
    ch_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || !ch_ready) && n < 5000) begin @(negedge clk); n++; end
    if (n >= 5000) begin
      total++; bad++;
      $display("FAIL idle_timeout: busy=%0b ready=%0b, required 0/1", busy, ch_ready);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 5000) begin n++; @(negedge clk); end
  endtask

  // Holds ch_valid high and streams printable bytes as fast as the console accepts.
  task automatic stream_print(input int nbytes, output int toggle_err, output int sent);
    int cyc;
    logic prev;
    logic [7:0] d, a;
    sent = 0; cyc = 0; toggle_err = 0; prev = 1'b0;
    while (sent < nbytes && cyc < 8 * nbytes + 100) begin
      if (cyc > 0 && ch_ready == prev) toggle_err++;
      prev = ch_ready;
      if (ch_ready) begin
        d = rand_printable(); a = 8'($urandom);
        ch_valid = 1'b1; ch_data = d; ch_attr = a;
        model_apply(d, a);
        sent++;
      end
      @(negedge clk);
      cyc++;
    end
    ch_valid = 1'b0;
  endtask

  task automatic check_screen(input string name);
    int n, fw;
    logic [31:0] got, exp;
    screen_diff(n, fw, got, exp);
    total++;
    if (n !== 0) begin
      bad++;
      $display("FAIL %s: %0d words differ, word %0d is %h, required %h", name, n, fw, got, exp);
    end
  endtask

  task automatic check_cursor(input string name);
    total++;
    if (cur_row !== 5'(m_row) || cur_col !== 7'(m_col)) begin
      bad++;
      $display("FAIL %s: cursor (%0d,%0d), required (%0d,%0d)", name, cur_row, cur_col,
               m_row, m_col);
    end
  endtask

  task automatic test_reset();
    int n;
    repeat (3) @(negedge clk);
    total++;
    if (ram_we !== 4'h0 || ch_ready !== 1'b0 || busy !== 1'b1 ||
        cur_row !== 5'd0 || cur_col !== 7'd0) begin
      bad++;
      $display("FAIL reset_state: we=%h ready=%0b busy=%0b cur=(%0d,%0d), required 0/0/1/(0,0)",
               ram_we, ch_ready, busy, cur_row, cur_col);
    end
    reset = 1'b0;
    m_row = 0; m_col = 0; model_fill(8'h0F);
    count_busy(n);
    total++;
    if (n !== 1200) begin
      bad++; $display("FAIL reset_clear_len: busy %0d cycles, required 1200", n);
    end
    wait_idle();
    check_screen("reset_clear_screen");
    check_cursor("reset_cursor");
    total++;
    if (ch_ready !== 1'b1) begin
      bad++; $display("FAIL reset_ready: ch_ready=%0b, required 1", ch_ready);
    end
  endtask

  task automatic test_put_pair();
    wlog.delete();
    send_byte(8'h41, 8'h1E);
    send_byte(8'h42, 8'h1E);
    wait_idle();
    total++;
    if (mem[0] !== 32'h1E411E42) begin
      bad++; $display("FAIL put_word0: got %h, required 1E411E42", mem[0]);
    end
    total++;
    if (wlog.size() != 2 || wlog[0] !== {4'hC, 11'd0} || wlog[1] !== {4'h3, 11'd0}) begin
      bad++; $display("FAIL put_enables: %0d writes, first %h, required 2 writes 6000 then 1800",
                      wlog.size(), (wlog.size() > 0) ? wlog[0] : 15'h0);
    end
    check_cursor("put_cursor");
    check_screen("put_screen");
  endtask

  task automatic test_back_to_back();
    int terr, sent;
    send_byte(8'h0D, 8'h00);
    wait_idle();
    wlog.delete();
    stream_print(81, terr, sent);
    total++;
    if (sent !== 81) begin
      bad++; $display("FAIL b2b_sent: %0d bytes accepted, required 81", sent);
    end
    total++;
    if (terr !== 0) begin
      bad++; $display("FAIL b2b_ready_toggle: %0d non-toggles, required 0", terr);
    end
    wait_idle();
    total++;
    if (wlog.size() == 0 || wlog[wlog.size()-1] !== {4'hC, 11'd40}) begin
      bad++; $display("FAIL b2b_wrap_write: last write %h, required %h",
                      (wlog.size() > 0) ? wlog[wlog.size()-1] : 15'h0, {4'hC, 11'd40});
    end
    check_cursor("b2b_cursor");
    check_screen("b2b_screen");
  endtask

  task automatic test_scroll();
    int terr, sent, n;
    send_byte(8'h0C, 8'($urandom));
    wait_idle();
    stream_print((ROWS - 1) * COLS + 5, terr, sent);
    wait_idle();
    check_cursor("scroll_pre_cursor");
    send_byte(8'h0A, 8'($urandom));
    count_busy(n);
    total++;
    if (n !== 2360) begin
      bad++; $display("FAIL scroll_len: busy %0d cycles, required 2360", n);
    end
    wait_idle();
    check_cursor("scroll_cursor");
    check_screen("scroll_screen");
  endtask

  task automatic test_controls();
    int n;
    logic [7:0] a;
    send_byte(8'h0C, 8'($urandom));
    wait_idle();
    for (int i = 0; i < 3; i++) send_byte(8'h0A, 8'h00);
    for (int i = 0; i < 7; i++) send_byte(rand_printable(), 8'($urandom));
    wait_idle();
    check_cursor("ctl_at_3_7");
    send_byte(8'h08, 8'h00);
    wait_idle();
    check_cursor("ctl_bs_mid");
    check_screen("ctl_bs_no_erase");
    send_byte(8'h0D, 8'h00);
    wait_idle();
    check_cursor("ctl_cr");
    send_byte(8'h08, 8'h00);
    wait_idle();
    check_cursor("ctl_bs_col0");
    a = 8'($urandom);
    send_byte(8'h0C, a);
    count_busy(n);
    total++;
    if (n !== 1200) begin
      bad++; $display("FAIL ctl_clear_len: busy %0d cycles, required 1200", n);
    end
    wait_idle();
    check_cursor("ctl_clear_cursor");
    check_screen("ctl_clear_screen");
  endtask

  task automatic test_random_mix();
    logic [7:0] d;
    int sel;
    for (int i = 0; i < 100; i++) begin
      sel = int'($urandom_range(0, 15));
      case (sel)
        0: d = 8'h0A;
        1: d = 8'h0D;
        2: d = 8'h08;
        default: d = rand_printable();
      endcase
      send_byte(d, 8'($urandom));
    end
    wait_idle();
    check_cursor("mix_cursor");
    check_screen("mix_screen");
  endtask

  task automatic test_reset_mid_scroll();
    int n;
    send_byte(8'h0C, 8'($urandom));
    wait_idle();
    for (int i = 0; i < ROWS - 1; i++) send_byte(8'h0A, 8'h00);
    send_byte(8'h0A, 8'($urandom));
    repeat (500) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (ram_we !== 4'h0 || cur_row !== 5'd0 || cur_col !== 7'd0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL midreset_state: we=%h cur=(%0d,%0d) busy=%0b, required 0,(0,0),1",
               ram_we, cur_row, cur_col, busy);
    end
    reset = 1'b0;
    m_row = 0; m_col = 0; model_fill(8'h0F);
    count_busy(n);
    total++;
    if (n !== 1200) begin
      bad++; $display("FAIL midreset_clear_len: busy %0d cycles, required 1200", n);
    end
    wait_idle();
    check_screen("midreset_screen");
    check_cursor("midreset_cursor");
  endtask

  task automatic test_bounds();
    total++;
    if (oob_writes !== 0) begin
      bad++; $display("FAIL write_bounds: %0d writes at addr>=1200, required 0", oob_writes);
    end
  endtask

  initial begin
    test_reset();
    test_put_pair();
    test_back_to_back();
    test_scroll();
    test_random_mix();
    test_controls();
    test_reset_mid_scroll();
    test_bounds();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
